// File: rtl/ex_stage_div_pkg.sv
// Shared encodings for the MIPS execute stage: ALUOp codes, opcodes and the
// divide sequencing states.
package ex_stage_div_pkg;

  localparam logic [1:0] ALUOP_NONE = 2'b00;
  localparam logic [1:0] ALUOP_ADD  = 2'b01;
  localparam logic [1:0] ALUOP_DIV  = 2'b10;
  localparam logic [1:0] ALUOP_CMP  = 2'b11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIVIDE = 2'd1,
    ST_DONE   = 2'd2
  } ex_state_e;

  // Only beq/bne resolve; any other opcode under ALUOP_CMP falls through.
  function automatic logic branch_taken(input logic [5:0] opcode, input logic equal);
    return ((opcode == OP_BEQ) && equal) || ((opcode == OP_BNE) && !equal);
  endfunction

endpackage

// File: rtl/ex_stage_div_if.sv
// ID/EX inputs and EX/WB outputs of the execute stage, bundled as one port.
interface ex_stage_div_if #(
  parameter int WIDTH = 32
);
  logic             Valid_in;
  logic [5:0]       OpCode_in;
  logic [1:0]       ALUOp_in;
  logic             RegDst_in;
  logic             ALUSrc_in;
  logic [WIDTH-1:0] PC_Plus_4_in;
  logic [WIDTH-1:0] ReadData1_in;
  logic [WIDTH-1:0] ReadData2_in;
  logic [WIDTH-1:0] SignExtend_in;
  logic [4:0]       Rt_in;
  logic [4:0]       Rd_in;

  logic [WIDTH-1:0] Result_out;
  logic [WIDTH-1:0] Remainder_out;
  logic [4:0]       WriteReg_out;
  logic             RegWrite_out;
  logic             BranchTaken_out;
  logic [WIDTH-1:0] BranchTarget_out;
  logic             FlushRegisters;
  logic             Stall;

  modport master (
    output Valid_in, OpCode_in, ALUOp_in, RegDst_in, ALUSrc_in, PC_Plus_4_in,
           ReadData1_in, ReadData2_in, SignExtend_in, Rt_in, Rd_in,
    input  Result_out, Remainder_out, WriteReg_out, RegWrite_out, BranchTaken_out,
           BranchTarget_out, FlushRegisters, Stall
  );

  modport slave (
    input  Valid_in, OpCode_in, ALUOp_in, RegDst_in, ALUSrc_in, PC_Plus_4_in,
           ReadData1_in, ReadData2_in, SignExtend_in, Rt_in, Rd_in,
    output Result_out, Remainder_out, WriteReg_out, RegWrite_out, BranchTaken_out,
           BranchTarget_out, FlushRegisters, Stall
  );
endinterface

// File: rtl/ex_stage_div_div_iter_core.sv
// Restoring unsigned divider retiring RADIX_BITS quotient bits per clock.
// A zero divisor naturally yields an all-ones quotient and remainder = dividend.
module div_iter_core #(
  parameter int WIDTH      = 32,
  parameter int RADIX_BITS = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int ITERS = WIDTH / RADIX_BITS;
  localparam int CW    = $clog2(ITERS + 1);

  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] quo_q, rem_q, div_q;
  logic [WIDTH-1:0] quo_nxt, rem_nxt;
  logic [WIDTH:0]   partial;

  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    quo_nxt = quo_q;
    rem_nxt = rem_q;
    partial = '0;
    // NOTE: blocking assignments here chain the RADIX_BITS steps within one cycle.
    for (int i = 0; i < RADIX_BITS; i++) begin
      partial = {rem_nxt, quo_nxt[WIDTH-1]};
      quo_nxt = {quo_nxt[WIDTH-2:0], 1'b0};
      if (partial >= {1'b0, div_q}) begin
        partial    = partial - {1'b0, div_q};
        quo_nxt[0] = 1'b1;
      end
      rem_nxt = partial[WIDTH-1:0];
    end
  end

  // The quotient register doubles as the dividend shift register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      count_q <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      div_q   <= '0;
    end else if (start) begin
      count_q <= CW'(ITERS);
      quo_q   <= dividend;
      rem_q   <= '0;
      div_q   <= divisor;
    end else if (count_q != '0) begin
      count_q <= count_q - CW'(1);
      quo_q   <= quo_nxt;
      rem_q   <= rem_nxt;
    end
  end

  // High during the final iteration; results are stable from the next cycle.
  assign done      = (count_q == CW'(1));
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/ex_stage_div.sv
// MIPS execute stage: addi, beq/bne resolution and an iterative divide that
// stalls upstream. Define DIV_SIGNED_EN for two's-complement division.
module ex_stage_div
  import ex_stage_div_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int RADIX_BITS = 1
) (
  input logic         Clk,
  input logic         Reset,
  ex_stage_div_if.slave bus
);

  ex_state_e        state_q;
  logic [WIDTH-1:0] op_a, op_b, br_target;
  logic [4:0]       dest_reg, div_wreg_q;
  logic             div_req, br_taken;

  logic [WIDTH-1:0] div_a, div_b, core_quo, core_rem, quo_fix, rem_fix;
  logic             core_done;

  assign op_a      = bus.ReadData1_in;
  assign op_b      = bus.ALUSrc_in ? bus.SignExtend_in : bus.ReadData2_in;
  assign dest_reg  = bus.RegDst_in ? bus.Rd_in : bus.Rt_in;
  assign br_taken  = branch_taken(bus.OpCode_in, op_a == op_b);
  assign br_target = bus.PC_Plus_4_in + {bus.SignExtend_in[WIDTH-3:0], 2'b00};
  assign div_req   = (state_q == ST_IDLE) && bus.Valid_in && (bus.ALUOp_in == ALUOP_DIV);

  // Upstream must hold from the request cycle until the writeback edge.
  assign bus.Stall = div_req || (state_q != ST_IDLE);

`ifdef DIV_SIGNED_EN
  logic q_neg_q, r_neg_q;

  assign div_a   = op_a[WIDTH-1] ? -op_a : op_a;
  assign div_b   = op_b[WIDTH-1] ? -op_b : op_b;
  // Magnitude arithmetic covers most-negative / -1 and divide-by-zero as well.
  assign quo_fix = q_neg_q ? -core_quo : core_quo;
  assign rem_fix = r_neg_q ? -core_rem : core_rem;
`else
  assign div_a   = op_a;
  assign div_b   = op_b;
  assign quo_fix = core_quo;
  assign rem_fix = core_rem;
`endif

  div_iter_core #(
    .WIDTH      (WIDTH),
    .RADIX_BITS (RADIX_BITS)
  ) u_div (
    .Clk       (Clk),
    .Reset     (Reset),
    .start     (div_req),
    .dividend  (div_a),
    .divisor   (div_b),
    .done      (core_done),
    .quotient  (core_quo),
    .remainder (core_rem)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q              <= ST_IDLE;
      div_wreg_q           <= '0;
      bus.Result_out       <= '0;
      bus.Remainder_out    <= '0;
      bus.WriteReg_out     <= '0;
      bus.RegWrite_out     <= 1'b0;
      bus.BranchTaken_out  <= 1'b0;
      bus.BranchTarget_out <= '0;
      bus.FlushRegisters   <= 1'b0;
`ifdef DIV_SIGNED_EN
      q_neg_q              <= 1'b0;
      r_neg_q              <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          bus.RegWrite_out    <= 1'b0;
          bus.BranchTaken_out <= 1'b0;
          bus.FlushRegisters  <= 1'b0;
          if (bus.Valid_in) begin
            case (bus.ALUOp_in)
              ALUOP_ADD: begin
                bus.Result_out   <= op_a + op_b;
                bus.WriteReg_out <= dest_reg;
                bus.RegWrite_out <= 1'b1;
              end
              ALUOP_CMP: begin
                if (br_taken) begin
                  bus.BranchTaken_out  <= 1'b1;
                  bus.FlushRegisters   <= 1'b1;
                  bus.BranchTarget_out <= br_target;
                end
              end
              ALUOP_DIV: begin
                div_wreg_q <= dest_reg;
                state_q    <= ST_DIVIDE;
`ifdef DIV_SIGNED_EN
                q_neg_q    <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
                r_neg_q    <= op_a[WIDTH-1];
`endif
              end
              default: ;
            endcase
          end
        end
        ST_DIVIDE: begin
          if (core_done) state_q <= ST_DONE;
        end
        ST_DONE: begin
          bus.Result_out    <= quo_fix;
          bus.Remainder_out <= rem_fix;
          bus.WriteReg_out  <= div_wreg_q;
          bus.RegWrite_out  <= 1'b1;
          state_q           <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_stage_div.sv
// Directed bench for ex_stage_div: single-cycle op table plus divide sequences.
module tb_ex_stage_div;
  import ex_stage_div_pkg::*;

  localparam int W       = 32;
  localparam int DIV_LAT = W / 1 + 2;

  logic Clk = 1'b0;
  logic Reset;
  int   n_vec = 0;
  int   n_err = 0;

  ex_stage_div_if #(.WIDTH(W)) ifc ();

  ex_stage_div #(.WIDTH(W), .RADIX_BITS(1)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (ifc)
  );

  always #5 Clk = ~Clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic        valid;
    logic [5:0]  opcode;
    logic [1:0]  aluop;
    logic        regdst;
    logic        alusrc;
    logic [31:0] pc4, a, b, se;
    logic [4:0]  rt, rd;
    logic [31:0] e_result;
    logic [4:0]  e_wreg;
    logic        e_rw;
    logic        e_taken;
    logic [31:0] e_target;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    ifc.Valid_in = 1'b0;      ifc.OpCode_in = OP_RTYPE; ifc.ALUOp_in = ALUOP_NONE;
    ifc.RegDst_in = 1'b0;     ifc.ALUSrc_in = 1'b0;     ifc.PC_Plus_4_in = '0;
    ifc.ReadData1_in = '0;    ifc.ReadData2_in = '0;    ifc.SignExtend_in = '0;
    ifc.Rt_in = '0;           ifc.Rd_in = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_result"},    ifc.Result_out, 0);
    check({tag, "_remainder"}, ifc.Remainder_out, 0);
    check({tag, "_wreg"},      32'(ifc.WriteReg_out), 0);
    check({tag, "_rw"},        32'(ifc.RegWrite_out), 0);
    check({tag, "_taken"},     32'(ifc.BranchTaken_out), 0);
    check({tag, "_flush"},     32'(ifc.FlushRegisters), 0);
    check({tag, "_target"},    ifc.BranchTarget_out, 0);
    check({tag, "_stall"},     32'(ifc.Stall), 0);
  endtask

  task automatic start_div(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    ifc.Valid_in = 1'b1;  ifc.OpCode_in = OP_RTYPE; ifc.ALUOp_in = ALUOP_DIV;
    ifc.RegDst_in = 1'b1; ifc.ALUSrc_in = 1'b0;
    ifc.ReadData1_in = a; ifc.ReadData2_in = b; ifc.Rd_in = rd; ifc.Rt_in = 5'd30;
  endtask

  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] eq, input logic [31:0] er);
    int stall_n = 0;
    int edges = 0;
    bit seen = 0;
    start_div(a, b, rd);
    #1;
    for (int c = 0; c < 100 && !seen; c++) begin
      if (ifc.Stall) stall_n++;
      @(posedge Clk); #1;
      edges++;
      if (c == 0) begin
        // Mid-divide garbage that must be ignored.
        ifc.ALUOp_in = ALUOP_ADD; ifc.ReadData1_in = 32'hDEAD_BEEF;
        ifc.ReadData2_in = 32'h55; ifc.Rd_in = 5'd9;
      end
      if (ifc.RegWrite_out) seen = 1;
    end
    check({tag, "_writeback_seen"}, 32'(seen), 1);
    check({tag, "_latency"},  edges, DIV_LAT);
    check({tag, "_stall_n"},  stall_n, DIV_LAT);
    check({tag, "_quotient"}, ifc.Result_out, eq);
    check({tag, "_remainder"}, ifc.Remainder_out, er);
    check({tag, "_wreg"},     32'(ifc.WriteReg_out), 32'(rd));
    drive_idle();
    #1;
    check({tag, "_stall_after"}, 32'(ifc.Stall), 0);
    @(posedge Clk); #1;
    check({tag, "_rw_pulse"}, 32'(ifc.RegWrite_out), 0);
    check({tag, "_rem_held"}, ifc.Remainder_out, er);
  endtask

  initial begin
    int pulses;
    // valid op aluop regdst alusrc pc4 a b se rt rd | result wreg rw taken target
    vecs[0]  = '{1'b1, OP_ADDI, ALUOP_ADD, 1'b0, 1'b1, 32'h0,   32'd5, 32'd0, 32'hFFFF_FFFD,
                 5'd8, 5'd0, 32'd2, 5'd8, 1'b1, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, OP_ADDI, ALUOP_ADD, 1'b0, 1'b1, 32'h0,   32'd9, 32'd0, 32'd1,
                 5'd4, 5'd0, 32'd2, 5'd8, 1'b0, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, OP_BEQ,  ALUOP_CMP, 1'b0, 1'b0, 32'h100, 32'd7, 32'd7, 32'd4,
                 5'd1, 5'd2, 32'd2, 5'd8, 1'b0, 1'b1, 32'h110};
    vecs[3]  = '{1'b0, OP_RTYPE, ALUOP_NONE, 1'b0, 1'b0, 32'h0, 32'd0, 32'd0, 32'd0,
                 5'd0, 5'd0, 32'd2, 5'd8, 1'b0, 1'b0, 32'h110};
    vecs[4]  = '{1'b1, OP_BNE,  ALUOP_CMP, 1'b0, 1'b0, 32'h100, 32'd7, 32'd7, 32'd4,
                 5'd1, 5'd2, 32'd2, 5'd8, 1'b0, 1'b0, 32'h110};
    vecs[5]  = '{1'b1, OP_BEQ,  ALUOP_CMP, 1'b0, 1'b0, 32'h300, 32'd7, 32'd8, 32'd4,
                 5'd1, 5'd2, 32'd2, 5'd8, 1'b0, 1'b0, 32'h110};
    vecs[6]  = '{1'b1, OP_BNE,  ALUOP_CMP, 1'b0, 1'b0, 32'h200, 32'd7, 32'd8, 32'hFFFF_FFFF,
                 5'd1, 5'd2, 32'd2, 5'd8, 1'b0, 1'b1, 32'h1FC};
    vecs[7]  = '{1'b1, OP_ADDI, ALUOP_ADD, 1'b1, 1'b0, 32'h0,   32'hFFFF_FFFF, 32'd1, 32'd100,
                 5'd2, 5'd31, 32'd0, 5'd31, 1'b1, 1'b0, 32'h1FC};
    vecs[8]  = '{1'b1, OP_ADDI, ALUOP_NONE, 1'b0, 1'b0, 32'h0,  32'd1, 32'd1, 32'd0,
                 5'd3, 5'd4, 32'd0, 5'd31, 1'b0, 1'b0, 32'h1FC};
    vecs[9]  = '{1'b1, OP_ADDI, ALUOP_CMP, 1'b0, 1'b0, 32'h40,  32'd3, 32'd3, 32'd1,
                 5'd3, 5'd4, 32'd0, 5'd31, 1'b0, 1'b0, 32'h1FC};
    vecs[10] = '{1'b1, OP_ADDI, ALUOP_ADD, 1'b0, 1'b1, 32'h0,   32'h7FFF_FFFF, 32'd0, 32'h10,
                 5'd5, 5'd6, 32'h8000_000F, 5'd5, 1'b1, 1'b0, 32'h1FC};

    drive_idle();
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    check_all_zero("reset");
    Reset = 1'b0;

    foreach (vecs[i]) begin
      ifc.Valid_in = vecs[i].valid;   ifc.OpCode_in = vecs[i].opcode;
      ifc.ALUOp_in = vecs[i].aluop;   ifc.RegDst_in = vecs[i].regdst;
      ifc.ALUSrc_in = vecs[i].alusrc; ifc.PC_Plus_4_in = vecs[i].pc4;
      ifc.ReadData1_in = vecs[i].a;   ifc.ReadData2_in = vecs[i].b;
      ifc.SignExtend_in = vecs[i].se; ifc.Rt_in = vecs[i].rt; ifc.Rd_in = vecs[i].rd;
      @(posedge Clk); #1;
      check($sformatf("v%0d_result", i), ifc.Result_out, vecs[i].e_result);
      check($sformatf("v%0d_wreg", i),   32'(ifc.WriteReg_out), 32'(vecs[i].e_wreg));
      check($sformatf("v%0d_rw", i),     32'(ifc.RegWrite_out), 32'(vecs[i].e_rw));
      check($sformatf("v%0d_taken", i),  32'(ifc.BranchTaken_out), 32'(vecs[i].e_taken));
      check($sformatf("v%0d_flush", i),  32'(ifc.FlushRegisters), 32'(vecs[i].e_taken));
      check($sformatf("v%0d_target", i), ifc.BranchTarget_out, vecs[i].e_target);
      check($sformatf("v%0d_stall", i),  32'(ifc.Stall), 0);
      check($sformatf("v%0d_rem", i),    ifc.Remainder_out, 0);
    end
    drive_idle();

    run_div("div100_7", 32'd100, 32'd7, 5'd3, 32'd14, 32'd2);
    run_div("div0",     32'h1234, 32'd0, 5'd4, 32'hFFFF_FFFF, 32'h1234);
`ifdef DIV_SIGNED_EN
    run_div("sdiv_m7_2",   32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_div("sdiv_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 32'h8000_0000, 32'd0);
    run_div("sdiv_m5_0",   32'hFFFF_FFFB, 32'd0, 5'd7, 32'd1, 32'hFFFF_FFFB);
`else
    run_div("udiv_big", 32'hFFFF_FFFF, 32'd2, 5'd5, 32'h7FFF_FFFF, 32'd1);
`endif

    // Reset in the middle of a divide discards it entirely.
    start_div(32'd100, 32'd7, 5'd3);
    repeat (10) @(posedge Clk);
    #1;
    drive_idle();
    Reset = 1'b1;
    @(posedge Clk); #1;
    check_all_zero("mid_reset");
    Reset = 1'b0;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge Clk); #1;
      if (ifc.RegWrite_out || ifc.Stall) pulses++;
    end
    check("post_reset_activity", pulses, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
